// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register file's single write port.
// In-order MEM/WB results win the port. Long-latency results wait in a small
// FIFO and drain on idle cycles. A pipe write kills older queued entries that
// target the same register. The FIFO head is aged so that upstream can be
// asked to bubble when the head starves.
module wb_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CW           = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          pipe_valid,
   input  logic [4:0]    pipe_rd,
   input  logic [31:0]   pipe_data,
   input  logic          lat_valid,
   input  logic [4:0]    lat_rd,
   input  logic [31:0]   lat_data,
   output logic          lat_ready,
   output logic [4:0]    rwd,
   output logic [31:0]   wb_data,
   output logic [31:0]   pending_mask,
   output logic [CW-1:0] fifo_count,
   output logic          wb_stall
);

   localparam int AW  = $clog2(DEPTH);
   localparam int AGW = $clog2(STARVE_LIMIT + 1);

   // live=0 marks a slot that is either free or holds a killed entry;
   // occupancy itself is tracked by the pointers and count.
   typedef struct packed {
      logic        live;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t [DEPTH-1:0] fifo_q, fifo_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AGW-1:0]   age_q, age_d;
   logic [4:0]       rwd_q, rwd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             wb_stall_q, wb_stall_d;

   logic full, empty, pipe_wr, pop, push;
   ent_t head;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pipe_wr = pipe_valid && (pipe_rd != 5'd0);
   // A pipe bubble (rd=0) leaves the port free for the FIFO.
   assign pop     = !pipe_wr && !empty;
   // Full is judged before the same-cycle pop, so a full FIFO never pushes.
   assign push    = lat_valid && !full && (lat_rd != 5'd0);
   assign head    = fifo_q[rd_ptr_q];

   assign lat_ready    = !full;
   assign rwd          = rwd_q;
   assign wb_data      = wb_data_q;
   assign fifo_count   = count_q;
   assign wb_stall     = wb_stall_q;

   // Next-state: port select, FIFO push/pop/kill, head aging.
   always_comb begin
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rwd_d      = 5'd0;
      wb_data_d  = wb_data_q;
      age_d      = age_q;

      if (pipe_wr) begin
         rwd_d     = pipe_rd;
         wb_data_d = pipe_data;
      end else if (pop && head.live) begin
         rwd_d     = head.rd;
         wb_data_d = head.data;
      end

      // Queued entries to the register the pipe writes are older; drop them.
      for (int i = 0; i < DEPTH; i++) begin
         if (pipe_wr && fifo_q[i].rd == pipe_rd) fifo_d[i].live = 1'b0;
      end

      if (pop) begin
         fifo_d[rd_ptr_q].live = 1'b0;
         rd_ptr_d              = rd_ptr_q + AW'(1);
      end

      // The push slot differs from the pop slot whenever both happen.
      if (push) begin
         fifo_d[wr_ptr_q].live = !(pipe_wr && lat_rd == pipe_rd);
         fifo_d[wr_ptr_q].rd   = lat_rd;
         fifo_d[wr_ptr_q].data = lat_data;
         wr_ptr_d              = wr_ptr_q + AW'(1);
      end

      count_d = count_q + CW'(push) - CW'(pop);

      if (pop || empty) age_d = '0;
      else if (age_q < AGW'(STARVE_LIMIT)) age_d = age_q + AGW'(1);

      wb_stall_d = (age_d >= AGW'(STARVE_LIMIT));
   end

   // Pending mask covers live entries only, so kills clear bits too.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_q[i].live) pending_mask[fifo_q[i].rd] = 1'b1;
      end
   end

   // State registers; reset drops any queued entries unwritten.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         age_q      <= '0;
         rwd_q      <= '0;
         wb_data_q  <= '0;
         wb_stall_q <= 1'b0;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         age_q      <= age_d;
         rwd_q      <= rwd_d;
         wb_data_q  <= wb_data_d;
         wb_stall_q <= wb_stall_d;
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, pipe priority, FIFO drain,
// full/refuse, WAW kill, rd=0 drop and starvation stall.
module tb_wb_write_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        lat_valid;
   logic [4:0]  lat_rd;
   logic [31:0] lat_data;
   logic        lat_ready;
   logic [4:0]  rwd;
   logic [31:0] wb_data;
   logic [31:0] pending_mask;
   logic [2:0]  fifo_count;
   logic        wb_stall;

   int checks   = 0;
   int failures = 0;

   wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .CW(3)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data),
      .lat_ready(lat_ready), .rwd(rwd), .wb_data(wb_data),
      .pending_mask(pending_mask), .fifo_count(fifo_count), .wb_stall(wb_stall)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic port(input string tag, input logic [4:0] r, input logic [31:0] d,
                       input logic [2:0] cnt, input logic [31:0] msk);
      chk({tag, ".rwd"}, 32'(rwd), 32'(r));
      chk({tag, ".data"}, wb_data, d);
      chk({tag, ".cnt"}, 32'(fifo_count), 32'(cnt));
      chk({tag, ".mask"}, pending_mask, msk);
   endtask

   initial begin
      RST_N = 1'b0; pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
      lat_valid = 0; lat_rd = 0; lat_data = 0;
      #2;
      port("reset", 5'd0, 32'h0, 3'd0, 32'h0);
      chk("reset.ready", 32'(lat_ready), 32'd1);
      chk("reset.stall", 32'(wb_stall), 32'd0);
      @(negedge CLK); RST_N = 1'b1;
      tick();

      // Pipe write, stable at negedge, then idle.
      pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
      tick();
      port("pipe", 5'd5, 32'hDEADBEEF, 3'd0, 32'h0);
      @(negedge CLK);
      port("pipe_neg", 5'd5, 32'hDEADBEEF, 3'd0, 32'h0);
      pipe_valid = 0;
      tick();
      port("idle", 5'd0, 32'hDEADBEEF, 3'd0, 32'h0);

      // Single long-latency result, 2-edge latency.
      lat_valid = 1; lat_rd = 9; lat_data = 32'h1234;
      tick();
      port("lat_push", 5'd0, 32'hDEADBEEF, 3'd1, 32'h200);
      lat_valid = 0;
      tick();
      port("lat_wr", 5'd9, 32'h1234, 3'd0, 32'h0);

      // Fill while pipe busy; rd=14 refused while full.
      pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h33;
      lat_valid = 1;
      for (int r = 10; r <= 13; r++) begin
         lat_rd = 5'(r); lat_data = 32'hC000_0000 | 32'(r);
         tick();
      end
      port("fill", 5'd3, 32'h33, 3'd4, 32'h3C00);
      chk("fill.ready", 32'(lat_ready), 32'd0);
      lat_rd = 14; lat_data = 32'hC000_000E;
      tick();
      port("full_refuse", 5'd3, 32'h33, 3'd4, 32'h3C00);
      chk("full.stall", 32'(wb_stall), 32'd0);
      pipe_valid = 0;
      tick();
      port("drain10", 5'd10, 32'hC000_000A, 3'd3, 32'h3800);
      chk("drain10.ready", 32'(lat_ready), 32'd1);
      tick();
      port("drain11", 5'd11, 32'hC000_000B, 3'd3, 32'h7000);
      lat_valid = 0;
      tick();
      port("drain12", 5'd12, 32'hC000_000C, 3'd2, 32'h6000);
      tick();
      port("drain13", 5'd13, 32'hC000_000D, 3'd1, 32'h4000);
      tick();
      port("drain14", 5'd14, 32'hC000_000E, 3'd0, 32'h0);
      tick();
      port("drain_idle", 5'd0, 32'hC000_000E, 3'd0, 32'h0);

      // WAW kill of an older queued entry.
      pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h22;
      lat_valid = 1; lat_rd = 7; lat_data = 32'hAAAA;
      tick();
      port("waw_q", 5'd2, 32'h22, 3'd1, 32'h80);
      lat_valid = 0; pipe_rd = 7; pipe_data = 32'hBBBB;
      tick();
      port("waw_kill", 5'd7, 32'hBBBB, 3'd1, 32'h0);
      pipe_valid = 0;
      tick();
      port("waw_pop", 5'd0, 32'hBBBB, 3'd0, 32'h0);

      // Same-cycle kill of the entry being enqueued.
      pipe_valid = 1; pipe_rd = 8; pipe_data = 32'h88;
      lat_valid = 1; lat_rd = 8; lat_data = 32'h8888;
      tick();
      port("same_kill", 5'd8, 32'h88, 3'd1, 32'h0);
      pipe_valid = 0; lat_valid = 0;
      tick();
      port("same_pop", 5'd0, 32'h88, 3'd0, 32'h0);

      // rd=0 offer is accepted and dropped.
      lat_valid = 1; lat_rd = 0; lat_data = 32'h5555;
      tick();
      port("rd0_drop", 5'd0, 32'h88, 3'd0, 32'h0);
      lat_valid = 0;

      // Pipe bubble (rd=0) lets the FIFO pop.
      lat_valid = 1; lat_rd = 6; lat_data = 32'h66;
      tick();
      lat_valid = 0; pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFF;
      tick();
      port("bubble_pop", 5'd6, 32'h66, 3'd0, 32'h0);
      pipe_valid = 0;

      // Starvation: 10 pipe cycles with one entry queued.
      pipe_valid = 1; pipe_rd = 4; pipe_data = 32'h44;
      lat_valid = 1; lat_rd = 20; lat_data = 32'h2020;
      tick();
      lat_valid = 0;
      chk("starve.mask", pending_mask, 32'h0010_0000);
      for (int k = 2; k <= 10; k++) begin
         tick();
         if (k == 8) chk("starve.e8", 32'(wb_stall), 32'd0);
         if (k == 9) chk("starve.e9", 32'(wb_stall), 32'd1);
      end
      chk("starve.e10", 32'(wb_stall), 32'd1);
      port("starve_hold", 5'd4, 32'h44, 3'd1, 32'h0010_0000);
      pipe_valid = 0;
      tick();
      port("starve_pop", 5'd20, 32'h2020, 3'd0, 32'h0);
      chk("starve.clear", 32'(wb_stall), 32'd0);

      // Reset mid-drain with 3 entries left queued.
      pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h11;
      lat_valid = 1;
      for (int r = 21; r <= 24; r++) begin
         lat_rd = 5'(r); lat_data = 32'(r);
         tick();
      end
      lat_valid = 0; pipe_valid = 0;
      tick();
      port("pre_rst", 5'd21, 32'd21, 3'd3, 32'h01C0_0000);
      #2 RST_N = 1'b0;
      #1;
      port("mid_rst", 5'd0, 32'h0, 3'd0, 32'h0);
      chk("mid_rst.ready", 32'(lat_ready), 32'd1);
      @(negedge CLK); RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         port("post_rst", 5'd0, 32'h0, 3'd0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
